tournament_table_port_sched: RTL

//  Schedules all accesses to the tournament predictor's single-port tables
//  (global PHT, local history/PHT, choice table). Lookups and resolved-branch

---
 rtl/tournament_table_port_sched.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/tournament_table_port_sched.sv
// Single-port table scheduler for the tournament predictor: lookups, buffered updates, starvation drain.
// Optional init sweep after reset is enabled by defining TOURN_INIT_SWEEP_EN.
module tournament_table_port_sched #(
  parameter int unsigned bht_idx_width_p = 8,
  parameter int unsigned upd_fifo_els_p  = 4,
  parameter int unsigned starve_limit_p  = 8,
  parameter logic [1:0]  init_val_p      = 2'b01
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       r_v_i,
  input  logic [bht_idx_width_p-1:0] r_idx_i,
  output logic                       r_ready_o,
  input  logic                       w_v_i,
  input  logic [bht_idx_width_p-1:0] w_idx_i,
  input  logic                       w_correct_i,
  input  logic                       w_taken_i,
  output logic                       w_ready_o,
  output logic                       tbl_v_o,
  output logic                       tbl_w_o,
  output logic [bht_idx_width_p-1:0] tbl_idx_o,
  output logic [1:0]                 tbl_wdata_o,
  output logic                       tbl_init_o,
  output logic                       busy_o
);

  localparam int unsigned ptr_w_lp = $clog2(upd_fifo_els_p);
  localparam int unsigned cnt_w_lp = $clog2(starve_limit_p + 1);

  typedef struct packed {
    logic [bht_idx_width_p-1:0] idx;
    logic                       correct;
    logic                       taken;
  } upd_s;

  typedef enum logic [1:0] {IDLE, INIT, FORCE} state_e;

  state_e                     state_q;
  upd_s                       mem_q [upd_fifo_els_p];
  logic [ptr_w_lp:0]          wr_ptr_q, rd_ptr_q;
  logic [ptr_w_lp:0]          wr_ptr_n, rd_ptr_n;
  logic [cnt_w_lp-1:0]        starve_q;
  logic                       w_ready_q;
  logic                       empty_c, full_c, full_n;
  logic                       init_c, lock_c, force_c, grant_c, drain_c, push_c;
  logic [bht_idx_width_p-1:0] sweep_c;
  upd_s                       head_c;

`ifdef TOURN_INIT_SWEEP_EN
  logic [bht_idx_width_p-1:0] sweep_q;
  logic                       init_done_q;

  // Sweep index and one-shot completion flag; the sweep starts the cycle after reset release.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sweep_q     <= '0;
      init_done_q <= 1'b0;
    end else if (state_q == INIT) begin
      sweep_q <= sweep_q + bht_idx_width_p'(1);
      if (sweep_q == '1) init_done_q <= 1'b1;
    end
  end

  assign init_c  = (state_q == INIT);
  assign lock_c  = init_c | ~init_done_q;
  assign sweep_c = sweep_q;
`else
  assign init_c  = 1'b0;
  assign lock_c  = 1'b0;
  assign sweep_c = '0;
`endif

  assign empty_c = (wr_ptr_q == rd_ptr_q);
  assign full_c  = (wr_ptr_q[ptr_w_lp] != rd_ptr_q[ptr_w_lp]) &&
                   (wr_ptr_q[ptr_w_lp-1:0] == rd_ptr_q[ptr_w_lp-1:0]);
  assign head_c  = mem_q[rd_ptr_q[ptr_w_lp-1:0]];

  // Arbitration: init sweep > forced drain > lookup > opportunistic drain.
  assign force_c = ~lock_c & (full_c | (starve_q == cnt_w_lp'(starve_limit_p)));
  assign grant_c = reset_n_i & r_v_i & ~force_c & ~lock_c;
  assign drain_c = ~lock_c & ~grant_c & ~empty_c;
  assign push_c  = w_v_i & w_ready_q;

  assign wr_ptr_n = wr_ptr_q + (ptr_w_lp + 1)'(push_c);
  assign rd_ptr_n = rd_ptr_q + (ptr_w_lp + 1)'(drain_c);
  assign full_n   = (wr_ptr_n[ptr_w_lp] != rd_ptr_n[ptr_w_lp]) &&
                    (wr_ptr_n[ptr_w_lp-1:0] == rd_ptr_n[ptr_w_lp-1:0]);

  always_comb begin
    tbl_v_o     = 1'b0;
    tbl_w_o     = 1'b0;
    tbl_idx_o   = '0;
    tbl_wdata_o = 2'b00;
    tbl_init_o  = 1'b0;
    if (init_c) begin
      tbl_v_o     = 1'b1;
      tbl_w_o     = 1'b1;
      tbl_idx_o   = sweep_c;
      tbl_wdata_o = init_val_p;
      tbl_init_o  = 1'b1;
    end else if (drain_c) begin
      tbl_v_o     = 1'b1;
      tbl_w_o     = 1'b1;
      tbl_idx_o   = head_c.idx;
      tbl_wdata_o = {head_c.correct, head_c.taken};
    end else if (grant_c) begin
      tbl_v_o   = 1'b1;
      tbl_idx_o = r_idx_i;
    end
  end

  assign r_ready_o = grant_c;
  assign w_ready_o = w_ready_q;
  assign busy_o    = init_c;

  // Payload storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk_i) begin
    if (push_c) mem_q[wr_ptr_q[ptr_w_lp-1:0]] <= '{idx: w_idx_i, correct: w_correct_i, taken: w_taken_i};
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      starve_q  <= '0;
      w_ready_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_n;
      rd_ptr_q  <= rd_ptr_n;
      w_ready_q <= ~full_n;
      if (drain_c) begin
        starve_q <= '0;
      end else if (grant_c && !empty_c && starve_q != cnt_w_lp'(starve_limit_p)) begin
        starve_q <= starve_q + cnt_w_lp'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (force_c) state_q <= FORCE;
`ifdef TOURN_INIT_SWEEP_EN
          if (!init_done_q) state_q <= INIT;
`endif
        end
`ifdef TOURN_INIT_SWEEP_EN
        INIT:    if (sweep_q == '1) state_q <= IDLE;
`endif
        FORCE:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
